// File: rtl/msf_pkg.sv
// msf_pkg: second indices, frame constants and the decoded-time record for the MSF decoder
package msf_pkg;
  localparam logic [5:0] SEC_YEAR    = 6'd17;
  localparam logic [5:0] SEC_MONTH   = 6'd25;
  localparam logic [5:0] SEC_DAY     = 6'd30;
  localparam logic [5:0] SEC_DOW     = 6'd36;
  localparam logic [5:0] SEC_HOUR    = 6'd39;
  localparam logic [5:0] SEC_MINUTE  = 6'd45;
  localparam logic [5:0] SEC_MARKER  = 6'd52;
  localparam logic [5:0] SEC_A_FIRST = 6'd17;
  localparam logic [5:0] SEC_B_FIRST = 6'd54;
  localparam logic [5:0] SEC_B_LAST  = 6'd57;
  localparam logic [7:0] MARKER_PATTERN = 8'b01111110;
  localparam logic [5:0] SECOND_UNSYNC  = 6'd63;
  localparam logic [5:0] SECOND_LAST    = 6'd59;
  // Field order matches transmission order, so A17..A51 maps straight onto this record
  typedef struct packed {
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day;
    logic [2:0] dow;
    logic [5:0] hour;
    logic [6:0] minute;
  } msf_time_t;
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= max;
  endfunction
endpackage

// File: rtl/msf_frame_check.sv
// msf_frame_check: combinational marker, odd-parity and BCD range check of a stored MSF frame
module msf_frame_check
  import msf_pkg::*;
(
  input  logic [SEC_A_FIRST:SECOND_LAST] i_a,
  input  logic [SEC_B_FIRST:SEC_B_LAST]  i_b,
  output logic                           o_pass
);
  msf_time_t w_t;
  logic w_mark, w_par, w_rng;
  assign w_t    = i_a[SEC_YEAR +: $bits(msf_time_t)];
  assign w_mark = i_a[SEC_MARKER +: 8] == MARKER_PATTERN;
  assign w_par  = (^{w_t.year, i_b[54]}) & (^{w_t.month, w_t.day, i_b[55]}) &
                  (^{w_t.dow, i_b[56]}) & (^{w_t.hour, w_t.minute, i_b[57]});
  assign w_rng  = bcd_ok(w_t.year, 8'h99) &&
                  bcd_ok({3'b0, w_t.month}, 8'h12) && w_t.month != 5'h0 &&
                  bcd_ok({2'b0, w_t.day}, 8'h31) && w_t.day != 6'h0 &&
                  w_t.dow <= 3'd6 &&
                  bcd_ok({2'b0, w_t.hour}, 8'h23) &&
                  bcd_ok({1'b0, w_t.minute}, 8'h59);
  assign o_pass = w_mark & w_par & w_rng;
endmodule

// File: rtl/msf_frame_decoder.sv
// msf_frame_decoder: tracks the MSF second index, stores A/B bits and latches checked time frames
module msf_frame_decoder
  import msf_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic [5:0] second_o,
  output logic       time_valid_o,
  output logic       frame_err_o,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] dow_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o
);
  logic [5:0] r_sec;
  logic [SEC_A_FIRST:SECOND_LAST] r_a;
  logic [SEC_B_FIRST:SEC_B_LAST] r_b;
  msf_time_t r_time;
  logic r_tv, r_fe;
  logic w_mark, w_data, w_pass;
  logic [5:0] w_next;
  assign w_mark = bits_valid_i & bits_is_second_00_i;
  assign w_data = bits_valid_i & ~bits_is_second_00_i;
  // Stepping past 59 means a long minute: drop sync rather than visit 60-62
  assign w_next = (r_sec == SECOND_UNSYNC || r_sec == SECOND_LAST) ? SECOND_UNSYNC : r_sec + 6'd1;
  msf_frame_check u_check (.i_a(r_a), .i_b(r_b), .o_pass(w_pass));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sec  <= SECOND_UNSYNC;
      r_a    <= '0;
      r_b    <= '0;
      r_time <= '0;
      r_tv   <= 1'b0;
      r_fe   <= 1'b0;
    end else begin
      r_tv <= 1'b0;
      r_fe <= 1'b0;
      if (w_mark) begin
        r_sec <= 6'd0;
        if (r_sec == SECOND_LAST) begin
          if (w_pass) r_time <= r_a[SEC_YEAR +: $bits(msf_time_t)];
          r_tv <= w_pass;
          r_fe <= ~w_pass;
        end else r_fe <= r_sec != SECOND_UNSYNC;
      end else if (w_data) begin
        r_sec <= w_next;
        if (w_next >= SEC_A_FIRST && w_next <= SECOND_LAST) r_a[w_next] <= bits_data_i[0];
        if (w_next >= SEC_B_FIRST && w_next <= SEC_B_LAST) r_b[w_next] <= bits_data_i[1];
      end
    end
  end
  assign second_o     = r_sec;
  assign time_valid_o = r_tv;
  assign frame_err_o  = r_fe;
  assign year_o       = r_time.year;
  assign month_o      = r_time.month;
  assign day_o        = r_time.day;
  assign dow_o        = r_time.dow;
  assign hour_o       = r_time.hour;
  assign minute_o     = r_time.minute;
endmodule

// File: tb/tb_msf_frame_decoder.sv
// tb_msf_frame_decoder: directed and randomised MSF frames checked against a decimal-arithmetic model
module tb_msf_frame_decoder;
  logic clk = 1'b0, rst_ni = 1'b0, bits_valid_i = 1'b0, bits_is_second_00_i = 1'b0;
  logic [1:0] bits_data_i = 2'b0;
  logic [5:0] second_o, day_o, hour_o;
  logic time_valid_o, frame_err_o;
  logic [7:0] year_o;
  logic [4:0] month_o;
  logic [2:0] dow_o;
  logic [6:0] minute_o;
  int checks = 0, errors = 0;
  int m_sec;
  bit m_a[60], m_b[60];
  int e_year, e_month, e_day, e_dow, e_hour, e_minute;
  bit e_tv, e_fe;

  always #5 clk = ~clk;

  msf_frame_decoder dut (
    .clk_i(clk), .rst_ni(rst_ni), .bits_valid_i(bits_valid_i),
    .bits_is_second_00_i(bits_is_second_00_i), .bits_data_i(bits_data_i),
    .second_o(second_o), .time_valid_o(time_valid_o), .frame_err_o(frame_err_o),
    .year_o(year_o), .month_o(month_o), .day_o(day_o), .dow_o(dow_o),
    .hour_o(hour_o), .minute_o(minute_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".second"}, 32'(second_o), m_sec);
    chk({tag, ".time_valid"}, 32'(time_valid_o), 32'(e_tv));
    chk({tag, ".frame_err"}, 32'(frame_err_o), 32'(e_fe));
    chk({tag, ".year"}, 32'(year_o), e_year);
    chk({tag, ".month"}, 32'(month_o), e_month);
    chk({tag, ".day"}, 32'(day_o), e_day);
    chk({tag, ".dow"}, 32'(dow_o), e_dow);
    chk({tag, ".hour"}, 32'(hour_o), e_hour);
    chk({tag, ".minute"}, 32'(minute_o), e_minute);
  endtask

  function automatic int getf(int s, int w);
    int v = 0;
    for (int i = 0; i < w; i++) v = v * 2 + int'(m_a[s + i]);
    return v;
  endfunction

  function automatic bit par_odd(int s, int w, int b);
    int c = int'(m_b[b]);
    for (int i = 0; i < w; i++) c += int'(m_a[s + i]);
    return c % 2 == 1;
  endfunction

  function automatic bit dec_ok(int v, int lo, int hi);
    int t = v / 16, u = v % 16;
    return t <= 9 && u <= 9 && 10 * t + u >= lo && 10 * t + u <= hi;
  endfunction

  function automatic bit model_pass();
    return getf(52, 8) == 'h7E &&
           par_odd(17, 8, 54) && par_odd(25, 11, 55) && par_odd(36, 3, 56) && par_odd(39, 13, 57) &&
           dec_ok(getf(17, 8), 0, 99) && dec_ok(getf(25, 5), 1, 12) && dec_ok(getf(30, 6), 1, 31) &&
           getf(36, 3) <= 6 && dec_ok(getf(39, 6), 0, 23) && dec_ok(getf(45, 7), 0, 59);
  endfunction

  task automatic model_reset();
    m_sec = 63;
    foreach (m_a[i]) begin m_a[i] = 0; m_b[i] = 0; end
    e_year = 0; e_month = 0; e_day = 0; e_dow = 0; e_hour = 0; e_minute = 0;
    e_tv = 0; e_fe = 0;
  endtask

  task automatic model_event(input bit mk, input logic [1:0] d);
    e_tv = 0; e_fe = 0;
    if (mk) begin
      if (m_sec == 59) begin
        if (model_pass()) begin
          e_tv = 1;
          e_year = getf(17, 8); e_month = getf(25, 5); e_day = getf(30, 6);
          e_dow = getf(36, 3); e_hour = getf(39, 6); e_minute = getf(45, 7);
        end else e_fe = 1;
      end else if (m_sec != 63) e_fe = 1;
      m_sec = 0;
    end else if (m_sec != 63) begin
      m_sec++;
      if (m_sec == 60) m_sec = 63;
      else begin m_a[m_sec] = d[0]; m_b[m_sec] = d[1]; end
    end
  endtask

  task automatic ev(input bit mk, input logic [1:0] d);
    @(negedge clk);
    bits_valid_i = 1'b1; bits_is_second_00_i = mk; bits_data_i = d;
    @(posedge clk); #1;
    bits_valid_i = 1'b0; bits_is_second_00_i = 1'($urandom); bits_data_i = 2'($urandom);
    model_event(mk, d);
    check_all(mk ? "marker" : "data");
    @(posedge clk); #1;
    e_tv = 0; e_fe = 0;
    check_all("idle");
  endtask

  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic send_frame(input logic [7:0] y, input logic [4:0] mo, input logic [5:0] dd,
                            input logic [2:0] dw, input logic [5:0] hh, input logic [6:0] mi,
                            input logic [3:0] bflip, input bit mbad, input int n);
    bit a[62], b[62];
    bit p;
    logic [7:0] mk = 8'b01111110;
    foreach (a[s]) begin a[s] = 1'($urandom); b[s] = 1'($urandom); end
    for (int i = 0; i < 8; i++) a[17 + i] = y[7 - i];
    for (int i = 0; i < 5; i++) a[25 + i] = mo[4 - i];
    for (int i = 0; i < 6; i++) a[30 + i] = dd[5 - i];
    for (int i = 0; i < 3; i++) a[36 + i] = dw[2 - i];
    for (int i = 0; i < 6; i++) a[39 + i] = hh[5 - i];
    for (int i = 0; i < 7; i++) a[45 + i] = mi[6 - i];
    for (int i = 0; i < 8; i++) a[52 + i] = mk[7 - i];
    if (mbad) a[52 + int'($urandom_range(0, 7))] ^= 1'b1;
    p = 1; for (int i = 17; i <= 24; i++) p ^= a[i]; b[54] = p;
    p = 1; for (int i = 25; i <= 35; i++) p ^= a[i]; b[55] = p;
    p = 1; for (int i = 36; i <= 38; i++) p ^= a[i]; b[56] = p;
    p = 1; for (int i = 39; i <= 51; i++) p ^= a[i]; b[57] = p;
    for (int k = 0; k < 4; k++) b[54 + k] ^= bflip[k];
    for (int s = 1; s <= n; s++) ev(1'b0, {b[s], a[s]});
    ev(1'b1, 2'($urandom));
  endtask

  initial begin
    logic [7:0] y, mo, dd, hh, mi;
    logic [2:0] dw;
    logic [3:0] fl;
    int k, n;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) ev(1'b0, 2'($urandom));
    ev(1'b1, 2'b00);
    send_frame(8'h23, 5'h03, 6'h15, 3'd3, 6'h14, 7'h27, 4'h0, 1'b0, 59);
    chk("good.year", 32'(year_o), 32'h23);
    chk("good.month", 32'(month_o), 32'h03);
    chk("good.day", 32'(day_o), 32'h15);
    chk("good.dow", 32'(dow_o), 32'h3);
    chk("good.hour", 32'(hour_o), 32'h14);
    chk("good.minute", 32'(minute_o), 32'h27);
    send_frame(8'h23, 5'h03, 6'h15, 3'd3, 6'h14, 7'h27, 4'b1000, 1'b0, 59);
    chk("b57.hour", 32'(hour_o), 32'h14);
    chk("b57.minute", 32'(minute_o), 32'h27);
    send_frame(8'h23, 5'h03, 6'h15, 3'd3, 6'h14, 7'h28, 4'h0, 1'b0, 58);
    chk("short.second", 32'(second_o), 32'h0);
    chk("short.minute", 32'(minute_o), 32'h27);
    send_frame(8'h99, 5'h12, 6'h31, 3'd6, 6'h23, 7'h59, 4'h0, 1'b0, 59);
    chk("max.year", 32'(year_o), 32'h99);
    chk("max.minute", 32'(minute_o), 32'h59);
    send_frame(8'h24, 5'h01, 6'h01, 3'd0, 6'h25, 7'h00, 4'h0, 1'b0, 59);
    chk("hour25.hour", 32'(hour_o), 32'h23);
    send_frame(8'h00, 5'h01, 6'h01, 3'd0, 6'h00, 7'h00, 4'h0, 1'b0, 59);
    chk("min.day", 32'(day_o), 32'h01);
    send_frame(8'h00, 5'h01, 6'h01, 3'd0, 6'h00, 7'h01, 4'h0, 1'b0, 60);
    for (int s = 1; s <= 30; s++) ev(1'b0, 2'($urandom));
    @(negedge clk) rst_ni = 1'b0;
    model_reset();
    #1 check_all("midreset");
    @(negedge clk) rst_ni = 1'b1;
    ev(1'b1, 2'b00);
    send_frame(8'h23, 5'h03, 6'h15, 3'd3, 6'h14, 7'h27, 4'h0, 1'b0, 59);
    chk("afterrst.hour", 32'(hour_o), 32'h14);
    for (int f = 0; f < 25; f++) begin
      k = int'($urandom_range(0, 9));
      y = bcd(int'($urandom_range(0, 99)));
      mo = bcd(int'($urandom_range(1, 12)));
      dd = bcd(int'($urandom_range(1, 31)));
      dw = 3'($urandom_range(0, 6));
      hh = bcd(int'($urandom_range(0, 23)));
      mi = bcd(int'($urandom_range(0, 59)));
      if (k == 6) begin
        case ($urandom_range(0, 5))
          0: y = 8'($urandom);
          1: mo = 8'($urandom);
          2: dd = 8'($urandom);
          3: dw = 3'($urandom);
          4: hh = 8'($urandom);
          default: mi = 8'($urandom);
        endcase
      end
      fl = (k == 7) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      n = 59;
      if (k == 9) begin
        case ($urandom_range(0, 3))
          0: n = 57;
          1: n = 58;
          2: n = 60;
          default: n = 61;
        endcase
      end
      send_frame(y, mo[4:0], dd[5:0], dw, hh[5:0], mi[6:0], fl, k == 8, n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
